serial_frame_decoder: RTL and testbench

Byte-level frame parser between the serial receiver and the morphologic GA debug core. It consumes single-cycle byte strobes from the UART receive path, validates framed commands (start byte, command, length, address, payload, XOR checksum), streams WRITE payloads into the image/pattern memory, and pulses a start request on a valid RUN frame. A receive timeout discards partial frames so a glitch on the serial line cannot wedge the link.

---
 rtl/serial_frame_decoder_pkg.sv | 19 +
 rtl/serial_frame_decoder_if.sv | 30 +++
 rtl/serial_frame_decoder_timeout.sv | 33 +++
 rtl/serial_frame_decoder.sv | 154 +++++++++++++++
 tb/tb_serial_frame_decoder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_decoder_pkg.sv
// Shared definitions for the serial frame decoder and its neighbours.
// Holds the parser state encoding, the command codes and the default
// start-of-frame byte.
package serial_frame_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        ADDR    = 3'd3,
        PAYLOAD = 3'd4,
        CHK     = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_RUN     = 8'h02;
    localparam logic [7:0] DEFAULT_SOF = 8'hAA;

endpackage

// File: rtl/serial_frame_decoder_if.sv
// Bundle between the UART receive path, the frame decoder and the
// image/pattern memory / GA core.
//   rxData, rxValid            : received byte and its one-cycle strobe
//   memWe, memAddr, memData    : registered memory write port
//   start, frameOk, frameError : one-cycle result pulses
//   busy                       : decoder is inside a frame
// master drives the receive side; slave is the decoder.
interface serial_frame_decoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rxData;
    logic                  rxValid;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [7:0]            memData;
    logic                  start;
    logic                  frameOk;
    logic                  frameError;
    logic                  busy;

    modport master (
        output rxData, rxValid,
        input  memWe, memAddr, memData, start, frameOk, frameError, busy
    );

    modport slave (
        input  rxData, rxValid,
        output memWe, memAddr, memData, start, frameOk, frameError, busy
    );
endinterface

// File: rtl/serial_frame_decoder_timeout.sv
// timeout_counter: reusable idle watchdog.
//   clk, rst : clock, synchronous active-high reset
//   clear    : reload the counter with LOAD (has priority over enable)
//   enable   : count down one per cycle
//   expired  : one-cycle pulse on the LOAD-th enabled cycle after a clear
module timeout_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LOAD  = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [WIDTH-1:0] count;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples its inputs from the same clock edge.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= LOAD;
        else if (enable && count != '0)
            count <= count - WIDTH'(1);
    end

    // Fires while the last remaining cycle is being spent; a clear in the
    // same cycle (a byte arriving) wins.
    assign expired = enable && !clear && (count == WIDTH'(1));

endmodule

// File: rtl/serial_frame_decoder.sv
// serial_frame_decoder: parses SOF/CMD/LEN/ADDR/PAYLOAD/CHK frames from
// the UART byte stream, streams WRITE payload into memory, pulses start
// on a good RUN frame and flags checksum/command/timeout errors.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_frame_decoder_if.slave (receive byte in, memory
//              write port and status pulses out)
module serial_frame_decoder
    import serial_frame_decoder_pkg::*;
#(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SOF        = DEFAULT_SOF,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_frame_decoder_if.slave  bus
);
    state_t                state, stateNext;
    logic [7:0]            cmdReg, cmdNext;
    logic [7:0]            lenReg, lenNext;
    logic [7:0]            chkReg, chkNext;
    logic                  goodCmd, goodNext;
    logic [ADDR_WIDTH-1:0] addrReg, addrNext;
    logic [ADDR_WIDTH-1:0] memAddrReg, memAddrNext;
    logic [7:0]            memDataReg, memDataNext;
    logic                  memWeReg, memWeNext;
    logic                  startReg, startNext;
    logic                  okReg, okNext;
    logic                  errReg, errNext;
    logic                  expired;

    timeout_counter #(
        .WIDTH (16),
        .LOAD  (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.rxValid),
        .enable  (state != IDLE),
        .expired (expired)
    );

    always_comb begin
        // NOTE: every next value is defaulted first so no path through the
        // case statement can infer a latch.
        stateNext   = state;
        cmdNext     = cmdReg;
        lenNext     = lenReg;
        chkNext     = chkReg;
        goodNext    = goodCmd;
        addrNext    = addrReg;
        memAddrNext = memAddrReg;
        memDataNext = memDataReg;
        memWeNext   = 1'b0;
        startNext   = 1'b0;
        okNext      = 1'b0;
        errNext     = 1'b0;

        if (bus.rxValid) begin
            unique case (state)
                IDLE: begin
                    if (bus.rxData == SOF) begin
                        stateNext = CMD;
                        chkNext   = 8'h00;
                    end
                end
                CMD: begin
                    cmdNext   = bus.rxData;
                    chkNext   = chkReg ^ bus.rxData;
                    stateNext = LEN;
                end
                LEN: begin
                    lenNext   = bus.rxData;
                    chkNext   = chkReg ^ bus.rxData;
                    // RUN must carry no payload; unknown codes are never good.
                    goodNext  = (cmdReg == CMD_WRITE) ||
                                (cmdReg == CMD_RUN && bus.rxData == 8'h00);
                    stateNext = ADDR;
                end
                ADDR: begin
                    addrNext  = ADDR_WIDTH'(bus.rxData);
                    chkNext   = chkReg ^ bus.rxData;
                    stateNext = (lenReg != 8'h00) ? PAYLOAD : CHK;
                end
                PAYLOAD: begin
                    chkNext = chkReg ^ bus.rxData;
                    // Writes go out before the checksum is known and are
                    // never rolled back.
                    if (goodCmd && cmdReg == CMD_WRITE) begin
                        memWeNext   = 1'b1;
                        memAddrNext = addrReg;
                        memDataNext = bus.rxData;
                    end
                    addrNext = addrReg + ADDR_WIDTH'(1);
                    lenNext  = lenReg - 8'd1;
                    if (lenReg == 8'd1)
                        stateNext = CHK;
                end
                CHK: begin
                    stateNext = IDLE;
                    if (goodCmd && bus.rxData == chkReg) begin
                        okNext    = 1'b1;
                        startNext = (cmdReg == CMD_RUN);
                    end else begin
                        errNext = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end else if (expired) begin
            stateNext = IDLE;
            errNext   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmdReg     <= 8'h00;
            lenReg     <= 8'h00;
            chkReg     <= 8'h00;
            goodCmd    <= 1'b0;
            addrReg    <= '0;
            memAddrReg <= '0;
            memDataReg <= 8'h00;
            memWeReg   <= 1'b0;
            startReg   <= 1'b0;
            okReg      <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            state      <= stateNext;
            cmdReg     <= cmdNext;
            lenReg     <= lenNext;
            chkReg     <= chkNext;
            goodCmd    <= goodNext;
            addrReg    <= addrNext;
            memAddrReg <= memAddrNext;
            memDataReg <= memDataNext;
            memWeReg   <= memWeNext;
            startReg   <= startNext;
            okReg      <= okNext;
            errReg     <= errNext;
        end
    end

    assign bus.memWe      = memWeReg;
    assign bus.memAddr    = memAddrReg;
    assign bus.memData    = memDataReg;
    assign bus.start      = startReg;
    assign bus.frameOk    = okReg;
    assign bus.frameError = errReg;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Self-checking bench for serial_frame_decoder: a table of byte strobes
// with hand-computed expected outputs, plus hand-written timeout and
// reset sequences. A short TIMEOUT keeps the silence tests quick.
module tb_serial_frame_decoder;

    localparam int T = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_frame_decoder_if #(.ADDR_WIDTH(8)) bus ();

    serial_frame_decoder #(
        .ADDR_WIDTH (8),
        .SOF        (8'hAA),
        .TIMEOUT    (16'(T))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       st;
        logic       ok;
        logic       err;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   passCnt  = 0;
    int   totalCnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // {memWe, memAddr, memData, start, frameOk, frameError, busy}
    function automatic logic [20:0] obs();
        return {bus.memWe, bus.memAddr, bus.memData,
                bus.start, bus.frameOk, bus.frameError, bus.busy};
    endfunction

    // {start, frameOk, frameError, memWe, busy}
    function automatic logic [4:0] flags();
        return {bus.start, bus.frameOk, bus.frameError, bus.memWe, bus.busy};
    endfunction

    task automatic add(input logic [7:0] b, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic st, input logic ok,
                       input logic err, input logic busy);
        vecs.push_back('{b, we, a, d, st, ok, err, busy});
    endtask

    // One-cycle strobe; returns 1 time unit after the sampling edge.
    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        bus.rxValid = 1'b1;
        bus.rxData  = b;
        @(posedge clk);
        #1;
        bus.rxValid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.rxValid = 1'b0;
        bus.rxData  = 8'h00;

        // WRITE 10..12 <= 11 22 33, chk = 01^03^10^11^22^33 = 12
        add(8'hAA,0,8'h00,8'h00,0,0,0,1); add(8'h01,0,8'h00,8'h00,0,0,0,1);
        add(8'h03,0,8'h00,8'h00,0,0,0,1); add(8'h10,0,8'h00,8'h00,0,0,0,1);
        add(8'h11,1,8'h10,8'h11,0,0,0,1); add(8'h22,1,8'h11,8'h22,0,0,0,1);
        add(8'h33,1,8'h12,8'h33,0,0,0,1); add(8'h12,0,8'h12,8'h33,0,1,0,0);
        // RUN, chk 02
        add(8'hAA,0,8'h12,8'h33,0,0,0,1); add(8'h02,0,8'h12,8'h33,0,0,0,1);
        add(8'h00,0,8'h12,8'h33,0,0,0,1); add(8'h00,0,8'h12,8'h33,0,0,0,1);
        add(8'h02,0,8'h12,8'h33,1,1,0,0);
        // WRITE with bad checksum (good would be 7B)
        add(8'hAA,0,8'h12,8'h33,0,0,0,1); add(8'h01,0,8'h12,8'h33,0,0,0,1);
        add(8'h01,0,8'h12,8'h33,0,0,0,1); add(8'h05,0,8'h12,8'h33,0,0,0,1);
        add(8'h7E,1,8'h05,8'h7E,0,0,0,1); add(8'h00,0,8'h05,8'h7E,0,0,1,0);
        // garbage then RUN
        add(8'h55,0,8'h05,8'h7E,0,0,0,0); add(8'h00,0,8'h05,8'h7E,0,0,0,0);
        add(8'hAA,0,8'h05,8'h7E,0,0,0,1); add(8'h02,0,8'h05,8'h7E,0,0,0,1);
        add(8'h00,0,8'h05,8'h7E,0,0,0,1); add(8'h00,0,8'h05,8'h7E,0,0,0,1);
        add(8'h02,0,8'h05,8'h7E,1,1,0,0);
        // unknown command 07 with matching checksum 7C still errors
        add(8'hAA,0,8'h05,8'h7E,0,0,0,1); add(8'h07,0,8'h05,8'h7E,0,0,0,1);
        add(8'h01,0,8'h05,8'h7E,0,0,0,1); add(8'h20,0,8'h05,8'h7E,0,0,0,1);
        add(8'h5A,0,8'h05,8'h7E,0,0,0,1); add(8'h7C,0,8'h05,8'h7E,0,0,1,0);
        // RUN with LEN 1, matching checksum 9A still errors
        add(8'hAA,0,8'h05,8'h7E,0,0,0,1); add(8'h02,0,8'h05,8'h7E,0,0,0,1);
        add(8'h01,0,8'h05,8'h7E,0,0,0,1); add(8'h00,0,8'h05,8'h7E,0,0,0,1);
        add(8'h99,0,8'h05,8'h7E,0,0,0,1); add(8'h9A,0,8'h05,8'h7E,0,0,1,0);
        // address wrap FE,FF,00 with SOF as payload data, chk 21
        add(8'hAA,0,8'h05,8'h7E,0,0,0,1); add(8'h01,0,8'h05,8'h7E,0,0,0,1);
        add(8'h03,0,8'h05,8'h7E,0,0,0,1); add(8'hFE,0,8'h05,8'h7E,0,0,0,1);
        add(8'hAA,1,8'hFE,8'hAA,0,0,0,1); add(8'hBB,1,8'hFF,8'hBB,0,0,0,1);
        add(8'hCC,1,8'h00,8'hCC,0,0,0,1); add(8'h21,0,8'h00,8'hCC,0,1,0,0);
        // WRITE with LEN 0 goes straight to CHK, chk 41
        add(8'hAA,0,8'h00,8'hCC,0,0,0,1); add(8'h01,0,8'h00,8'hCC,0,0,0,1);
        add(8'h00,0,8'h00,8'hCC,0,0,0,1); add(8'h40,0,8'h00,8'hCC,0,0,0,1);
        add(8'h41,0,8'h00,8'hCC,0,1,0,0);

        repeat (3) @(posedge clk);
        #1;
        check("reset state", obs(), 21'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            strobe(vecs[i].b);
            check($sformatf("vec%0d byte %h", i, vecs[i].b), obs(),
                  {vecs[i].we, vecs[i].addr, vecs[i].data,
                   vecs[i].st, vecs[i].ok, vecs[i].err, vecs[i].busy});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d gap", i), flags(), {4'b0000, vecs[i].busy});
        end

        // Timeout: silence for T cycles after the command byte.
        strobe(8'hAA);
        strobe(8'h01);
        repeat (T - 1) @(posedge clk);
        #1;
        check("timeout not yet", flags(), 5'b00001);
        @(posedge clk);
        #1;
        check("timeout fires", flags(), 5'b00100);
        @(posedge clk);
        #1;
        check("timeout pulse one cycle", flags(), 5'b00000);
        strobe(8'hAA); strobe(8'h02); strobe(8'h00); strobe(8'h00);
        strobe(8'h02);
        check("run after timeout", flags(), 5'b11000);

        // A byte arriving in the expiring cycle wins.
        strobe(8'hAA);
        strobe(8'h01);
        repeat (T - 1) @(posedge clk);
        strobe(8'h00);
        check("byte beats timeout", flags(), 5'b00001);
        strobe(8'h00);
        strobe(8'h01);
        check("frame after near timeout", flags(), 5'b01000);

        // Reset after 2 of 4 payload bytes.
        strobe(8'hAA); strobe(8'h01); strobe(8'h04); strobe(8'h30);
        strobe(8'hA1);
        check("payload before reset", obs(), {1'b1, 8'h30, 8'hA1, 4'b0001});
        strobe(8'hA2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset mid-payload", obs(), 21'd0);
        @(negedge clk);
        rst = 1'b0;
        strobe(8'hB3);
        check("post-reset byte ignored", obs(), 21'd0);
        strobe(8'hB4);
        check("post-reset byte ignored 2", obs(), 21'd0);
        strobe(8'hAA); strobe(8'h01); strobe(8'h01); strobe(8'h50);
        strobe(8'hC5);
        check("write after reset", obs(), {1'b1, 8'h50, 8'hC5, 4'b0001});
        strobe(8'h95);
        check("frame ok after reset", obs(), {1'b0, 8'h50, 8'hC5, 4'b0100});

        // Reset together with the CHK byte suppresses start/frameOk.
        strobe(8'hAA); strobe(8'h02); strobe(8'h00); strobe(8'h00);
        @(negedge clk);
        rst         = 1'b1;
        bus.rxValid = 1'b1;
        bus.rxData  = 8'h02;
        @(posedge clk);
        #1;
        bus.rxValid = 1'b0;
        check("reset suppresses pulse", obs(), 21'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle after suppressed pulse", flags(), 5'b00000);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
